// File: rtl/seq_inverse_shifter_if.sv
// Start/done handshake and operand bus between the ALU and the sequential inverse shifter.
// The master drives the request fields; the slave (the shifter) returns status and the result.
interface seq_inverse_shifter_if #(
  parameter int unsigned Width = 16,
  parameter int unsigned ValW  = 4
);
  logic             start;
  logic [Width-1:0] Shift_In;
  logic [ValW-1:0]  Shift_Val;
  logic [1:0]       Opcode;
  logic             busy;
  logic             done;
  logic [Width-1:0] Shift_Out;

  modport master (
    output start, Shift_In, Shift_Val, Opcode,
    input  busy, done, Shift_Out
  );

  modport slave (
    input  start, Shift_In, Shift_Val, Opcode,
    output busy, done, Shift_Out
  );
endinterface

// File: rtl/seq_inverse_shifter.sv
// Multi-cycle SRL/ROL/SLL unit: the shift amount is split into radix-3 digits (weights 1, 3, 9),
// one digit applied per cycle through a shared stage, giving a fixed accept-to-done latency of 4.
module seq_inverse_shifter #(
  parameter int unsigned Width = 16,  // only 16 is supported
  parameter int unsigned ValW  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_inverse_shifter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StD0, StD1, StD2, StDone} state_e;

  localparam logic [4:0] WidthAmt = 5'(Width);

  state_e           state_q, state_d;
  logic [Width-1:0] work_q, work_d;
  logic [Width-1:0] out_q, out_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       d0_q, d0_d, d1_q, d1_d;
  logic             d2_q, d2_d;

  logic [1:0]       d0_new, d1_new;
  logic             d2_new;
  logic [ValW-1:0]  rem9;
  logic [3:0]       amt;
  logic [Width-1:0] stage_res;

  // Radix-3 decomposition of the requested amount (0..15).
  always_comb begin
    d2_new = (bus.Shift_Val >= ValW'(9));
    rem9   = d2_new ? (bus.Shift_Val - ValW'(9)) : bus.Shift_Val;
    case (rem9)
      4'd1:    {d1_new, d0_new} = 4'b00_01;
      4'd2:    {d1_new, d0_new} = 4'b00_10;
      4'd3:    {d1_new, d0_new} = 4'b01_00;
      4'd4:    {d1_new, d0_new} = 4'b01_01;
      4'd5:    {d1_new, d0_new} = 4'b01_10;
      4'd6:    {d1_new, d0_new} = 4'b10_00;
      4'd7:    {d1_new, d0_new} = 4'b10_01;
      4'd8:    {d1_new, d0_new} = 4'b10_10;
      default: {d1_new, d0_new} = 4'b00_00;
    endcase
  end

  // Amount for the digit owned by the current state.
  always_comb begin
    amt = 4'd0;
    unique case (state_q)
      StD0:    amt = {2'b00, d0_q};
      StD1:    amt = {1'b0, d1_q, 1'b0} + {2'b00, d1_q};
      StD2:    amt = d2_q ? 4'd9 : 4'd0;
      default: amt = 4'd0;
    endcase
  end

  always_comb begin
    unique case (op_q)
      2'b00:   stage_res = work_q >> amt;
      // amt == 0 makes the right-hand shift equal the width, which yields zero.
      2'b01:   stage_res = (work_q << amt) | (work_q >> (WidthAmt - {1'b0, amt}));
      2'b10:   stage_res = work_q << amt;
      default: stage_res = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    op_d    = op_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StD0;
          work_d  = bus.Shift_In;
          op_d    = bus.Opcode;
          if (bus.Opcode == 2'b11) begin
            d0_d = 2'd0;
            d1_d = 2'd0;
            d2_d = 1'b0;
          end else begin
            d0_d = d0_new;
            d1_d = d1_new;
            d2_d = d2_new;
          end
        end
      end
      StD0: begin
        work_d  = stage_res;
        state_d = StD1;
      end
      StD1: begin
        work_d  = stage_res;
        state_d = StD2;
      end
      StD2: begin
        out_d   = stage_res;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      out_q   <= '0;
      op_q    <= 2'b00;
      d0_q    <= 2'd0;
      d1_q    <= 2'd0;
      d2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      op_q    <= op_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.Shift_Out = out_q;

endmodule

// File: tb/tb_seq_inverse_shifter.sv
// Directed plus random checks of seq_inverse_shifter: latency, busy/done timing, result hold,
// ignored starts, back-to-back ops and asynchronous abort.
module tb_seq_inverse_shifter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] sb[$];
  logic [15:0] last_exp;

  seq_inverse_shifter_if #(.Width(16), .ValW(4)) bus ();

  seq_inverse_shifter #(.Width(16), .ValW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-at-a-time reference, independent of the digit decomposition.
  function automatic logic [15:0] model(input logic [15:0] x, input logic [3:0] v,
                                        input logic [1:0] op);
    logic [15:0] r;
    r = x;
    for (int i = 0; i < int'(v); i++) begin
      case (op)
        2'b00:   r = {1'b0, r[15:1]};
        2'b01:   r = {r[14:0], r[15]};
        2'b10:   r = {r[14:0], 1'b0};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  task automatic idle_hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "/idle_busy"}, 16'(bus.busy), 16'd0);
      check({tag, "/idle_done"}, 16'(bus.done), 16'd0);
      check({tag, "/idle_hold"}, bus.Shift_Out, last_exp);
    end
  endtask

  // Issues one op at the next falling edge, then checks the four busy cycles and the result.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [3:0] v,
                        input logic [1:0] op, input logic [15:0] exp, input bit poke);
    logic [15:0] want;
    @(negedge clk);
    check({tag, "/pre_busy"}, 16'(bus.busy), 16'd0);
    check({tag, "/pre_done"}, 16'(bus.done), 16'd0);
    check({tag, "/pre_hold"}, bus.Shift_Out, last_exp);
    bus.start     = 1'b1;
    bus.Shift_In  = x;
    bus.Shift_Val = v;
    bus.Opcode    = op;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.Shift_In  = 16'($urandom);
    bus.Shift_Val = 4'($urandom);
    bus.Opcode    = 2'($urandom);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = (poke && c == 2);
      check({tag, "/busy"}, 16'(bus.busy), 16'd1);
      check({tag, "/done"}, 16'(bus.done), 16'(c == 4));
      if (c < 4) begin
        check({tag, "/old_hold"}, bus.Shift_Out, last_exp);
      end else begin
        want = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        check({tag, "/result"}, bus.Shift_Out, want);
        last_exp = want;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    logic [15:0] rx;
    logic [3:0]  rv;
    logic [1:0]  rop;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.Shift_In  = 16'hFFFF;
    bus.Shift_Val = 4'hF;
    bus.Opcode    = 2'b01;
    last_exp      = 16'h0000;
    #2;
    check("reset/busy", 16'(bus.busy), 16'd0);
    check("reset/done", 16'(bus.done), 16'd0);
    check("reset/out", bus.Shift_Out, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_hold("post_reset", 2);

    run_op("srl_f000_12", 16'hF000, 4'd12, 2'b00, 16'h000F, 1'b0);
    run_op("rol_1234_4", 16'h1234, 4'd4, 2'b01, 16'h2341, 1'b0);
    run_op("rol_8001_15", 16'h8001, 4'd15, 2'b01, 16'hC000, 1'b0);
    run_op("sll_00ff_14", 16'h00FF, 4'd14, 2'b10, 16'hC000, 1'b0);
    run_op("srl_zero", 16'hABCD, 4'd0, 2'b00, 16'hABCD, 1'b0);
    run_op("rol_zero", 16'hABCD, 4'd0, 2'b01, 16'hABCD, 1'b0);
    run_op("sll_zero", 16'hABCD, 4'd0, 2'b10, 16'hABCD, 1'b0);
    run_op("srl_8000_15", 16'h8000, 4'd15, 2'b00, 16'h0001, 1'b0);
    run_op("pass_5a5a_poke", 16'h5A5A, 4'd7, 2'b11, 16'h5A5A, 1'b1);
    idle_hold("pass_hold", 3);
    run_op("sll_0001_9", 16'h0001, 4'd9, 2'b10, 16'h0200, 1'b0);
    run_op("rol_f00f_8", 16'hF00F, 4'd8, 2'b01, 16'h0FF0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rx  = 16'($urandom);
      rv  = 4'($urandom);
      rop = 2'($urandom);
      run_op($sformatf("rand%0d_op%0d_v%0d", i, rop, rv), rx, rv, rop, model(rx, rv, rop), 1'b0);
    end

    // Abort mid-operation.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.Shift_In  = 16'h1357;
    bus.Shift_Val = 4'd5;
    bus.Opcode    = 2'b01;
    sb.push_back(model(16'h1357, 4'd5, 2'b01));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("abort/busy_before", 16'(bus.busy), 16'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/busy", 16'(bus.busy), 16'd0);
    check("abort/done", 16'(bus.done), 16'd0);
    check("abort/out", bus.Shift_Out, 16'h0000);
    sb.delete();
    last_exp = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    idle_hold("abort_no_done", 6);

    run_op("after_abort_srl", 16'hBEEF, 4'd3, 2'b00, model(16'hBEEF, 4'd3, 2'b00), 1'b0);
    run_op("after_abort_rol", 16'h8421, 4'd13, 2'b01, model(16'h8421, 4'd13, 2'b01), 1'b0);
    idle_hold("final", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
